wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage MIPS pipeline, directly downstream of the memory stage. Holds the M/W pipeline register with stall/flush control and aligns and extends load data. Selects the register-file write value and owns the architectural HI/LO registers, with same-cycle bypass on their read ports. Also drives the debug trace outputs, one commit per retired instruction.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, value of W-stage PC register and debug_wb_pc after reset

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- w_stall  in  1  hold W register; no commit this cycle
- w_flush  in  1  invalidate incoming M instruction (exception / eret in M)
- m_valid  in  1  M stage holds a real instruction (is_instr)
- m_regwrite, m_memtoreg, m_mfc0, m_link, m_hi_wen, m_lo_wen  in  1 each  M control bits
- m_load_type  in  3  load_t from shared package
- m_reg_waddr  in  5  destination GPR
- m_ex_out  in  32  ALU result / data address
- m_data_rdata  in  32  raw word from data SRAM-like port
- m_cp0_rdata  in  32  mfc0 read value
- m_pc, m_hi_wdata, m_lo_wdata  in  32 each
- rf_wen  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- hi_rdata, lo_rdata  out  32 each  HI/LO with W bypass
- w_valid  out  1  W register holds a valid instruction (hazard unit)
- debug_wb_pc  out  32
- debug_wb_rf_wen  out  4
- debug_wb_rf_wnum  out  5
- debug_wb_rf_wdata  out  32

## Operation

- W register update, priority rst > w_stall > w_flush > load.
- w_stall: all W fields hold. w_flush while not stalled: w_valid<=0, other fields don't-care.
- Load: capture every m_* field; w_valid<=m_valid.
- Load extend on W copy of m_data_rdata, offset = w_ex_out[1:0]:
  - LD_W: word unchanged.
  - LD_H / LD_HU: halfword at offset[1], sign- or zero-extended.
  - LD_B / LD_BU: byte at offset, sign- or zero-extended.
  - Misaligned loads never reach W; they are trapped in M.
- rf_wdata select, first match wins: memtoreg -> extended load; mfc0 -> w_cp0_rdata; link -> w_pc+8 (32-bit wrap); else w_ex_out.
- rf_wen = w_valid & w_regwrite & (w_reg_waddr != 0). rf_waddr = w_reg_waddr.
- Repeated rf_wen during stall is harmless; the value is identical.
- HI/LO commit on the edge where w_valid & ~w_stall and the matching wen is set. Only one commit per instruction.
- hi_rdata = (w_valid & w_hi_wen) ? w_hi_wdata : hi_reg; lo_rdata likewise.
- Debug: debug_wb_rf_wen = {4{rf_wen & ~w_stall}}; wnum/wdata mirror rf_waddr/rf_wdata; debug_wb_pc = w_pc.

## Timing

- Reset (rst=0 at edge): w_valid=0, all W fields 0, w_pc=RESET_PC, hi_reg=lo_reg=0.
- Consequently at reset every output is 0, except debug_wb_pc=RESET_PC.
- Latency: M values visible on rf_* one cycle after the capturing edge. rf_* are combinational from the W register.
- HI/LO: new value is visible on hi_rdata in the same cycle W holds it (bypass), and in hi_reg from the next edge.
- Stall and flush high together: stall wins, W holds, the flush is lost; the hazard unit must keep flush asserted.
- Reset mid-stall: reset wins, W is cleared, no HI/LO commit.

## Structure

- load_t enum goes in cpu_defs (LD_W=0, LD_H=1, LD_HU=2, LD_B=3, LD_BU=4), next to the existing ctrl/dp structs.
- A dp_mtow-compatible struct may replace the flat m_* data ports.
- One sub-module, load_extend: combinational; inputs raw word, offset, and load_t; output 32-bit value.

## Test plan

- lw at addr 0x...4, rdata 0x8899AABB -> next cycle rf_wen=1, rf_wdata=0x8899AABB, debug_wb_rf_wen=4'hF.
- lb offset 3 on rdata 0x80112233 -> rf_wdata=0xFFFFFF80; lbu -> 0x00000080; lh offset 2 -> 0xFFFF8011.
- jal at pc 0x00400010, link=1, waddr 31 -> rf_wdata=0x00400018; regwrite with waddr 0 -> rf_wen=0.
- mthi 0x12345678 with w_stall held 3 cycles:
  - hi_rdata=0x12345678 throughout.
  - hi_reg is written once, after stall release.
  - debug_wb_rf_wen stays 0 while stalled.
- w_flush with m_valid=1, regwrite=1 -> next cycle w_valid=0, rf_wen=0; HI/LO unchanged.
- rst=0 asserted during a valid mult commit cycle -> hi/lo stay 0, all outputs at their reset values.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared load kinds and the W pipeline register layout
package wb_stage_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } load_t;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        mfc0;
        logic        link;
        logic        hi_wen;
        logic        lo_wen;
        load_t       load_type;
        logic [4:0]  reg_waddr;
        logic [31:0] ex_out;
        logic [31:0] data_rdata;
        logic [31:0] cp0_rdata;
        logic [31:0] pc;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
    } w_reg_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: M-to-W bus, hazard controls and writeback/debug results
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic        w_stall;
    logic        w_flush;
    logic        m_valid;
    logic        m_regwrite;
    logic        m_memtoreg;
    logic        m_mfc0;
    logic        m_link;
    logic        m_hi_wen;
    logic        m_lo_wen;
    load_t       m_load_type;
    logic [4:0]  m_reg_waddr;
    logic [31:0] m_ex_out;
    logic [31:0] m_data_rdata;
    logic [31:0] m_cp0_rdata;
    logic [31:0] m_pc;
    logic [31:0] m_hi_wdata;
    logic [31:0] m_lo_wdata;

    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic        w_valid;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    modport master (
        output w_stall, w_flush, m_valid, m_regwrite, m_memtoreg, m_mfc0, m_link,
               m_hi_wen, m_lo_wen, m_load_type, m_reg_waddr, m_ex_out, m_data_rdata,
               m_cp0_rdata, m_pc, m_hi_wdata, m_lo_wdata,
        input  rf_wen, rf_waddr, rf_wdata, hi_rdata, lo_rdata, w_valid, debug_wb_pc,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport slave (
        input  w_stall, w_flush, m_valid, m_regwrite, m_memtoreg, m_mfc0, m_link,
               m_hi_wen, m_lo_wen, m_load_type, m_reg_waddr, m_ex_out, m_data_rdata,
               m_cp0_rdata, m_pc, m_hi_wdata, m_lo_wdata,
        output rf_wen, rf_waddr, rf_wdata, hi_rdata, lo_rdata, w_valid, debug_wb_pc,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// load_extend: picks the addressed byte/halfword of a load word and extends it
module load_extend
    import wb_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  load_t       load_type,
    output logic [31:0] value
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half   = offset[1] ? raw[31:16] : raw[15:0];
    assign byte_v = raw[{offset, 3'b000} +: 8];

    // Extension by load kind; word loads and unused codes pass the word through.
    always_comb begin
        value = (load_type == LD_H)  ? {{16{half[15]}}, half} :
                (load_type == LD_HU) ? {16'h0000, half} :
                (load_type == LD_B)  ? {{24{byte_v[7]}}, byte_v} :
                (load_type == LD_BU) ? {24'h000000, byte_v} : raw;
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W register, writeback value select, HI/LO ownership and debug trace
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave wb
);

    w_reg_t      w_d, w_q;
    logic [31:0] hi_d, hi_q, lo_d, lo_q;
    logic [31:0] load_val;
    logic        retire;

    load_extend u_load_extend (
        .raw       (w_q.data_rdata),
        .offset    (w_q.ex_out[1:0]),
        .load_type (w_q.load_type),
        .value     (load_val)
    );

    // Next W contents: a stall holds everything, a flush only kills valid.
    always_comb begin
        w_d = w_q;
        if (!wb.w_stall) begin
            w_d.valid      = wb.m_valid & ~wb.w_flush;
            w_d.regwrite   = wb.m_regwrite;
            w_d.memtoreg   = wb.m_memtoreg;
            w_d.mfc0       = wb.m_mfc0;
            w_d.link       = wb.m_link;
            w_d.hi_wen     = wb.m_hi_wen;
            w_d.lo_wen     = wb.m_lo_wen;
            w_d.load_type  = wb.m_load_type;
            w_d.reg_waddr  = wb.m_reg_waddr;
            w_d.ex_out     = wb.m_ex_out;
            w_d.data_rdata = wb.m_data_rdata;
            w_d.cp0_rdata  = wb.m_cp0_rdata;
            w_d.pc         = wb.m_pc;
            w_d.hi_wdata   = wb.m_hi_wdata;
            w_d.lo_wdata   = wb.m_lo_wdata;
        end
    end

    // HI/LO change only on the one unstalled edge that retires the instruction.
    always_comb begin
        retire = w_q.valid & ~wb.w_stall;
        hi_d   = (retire & w_q.hi_wen) ? w_q.hi_wdata : hi_q;
        lo_d   = (retire & w_q.lo_wen) ? w_q.lo_wdata : lo_q;
    end

    // State update; reset beats any pending stall or retire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_q    <= '0;
            w_q.pc <= RESET_PC;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            w_q  <= w_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Writeback value, HI/LO bypass and commit trace, all straight from W.
    always_comb begin
        wb.rf_wen            = w_q.valid & w_q.regwrite & (w_q.reg_waddr != 5'd0);
        wb.rf_waddr          = w_q.reg_waddr;
        wb.rf_wdata          = w_q.memtoreg ? load_val :
                               w_q.mfc0     ? w_q.cp0_rdata :
                               w_q.link     ? w_q.pc + LINK_OFFSET : w_q.ex_out;
        wb.hi_rdata          = (w_q.valid & w_q.hi_wen) ? w_q.hi_wdata : hi_q;
        wb.lo_rdata          = (w_q.valid & w_q.lo_wen) ? w_q.lo_wdata : lo_q;
        wb.w_valid           = w_q.valid;
        wb.debug_wb_pc       = w_q.pc;
        wb.debug_wb_rf_wen   = {4{wb.rf_wen & ~wb.w_stall}};
        wb.debug_wb_rf_wnum  = wb.rf_waddr;
        wb.debug_wb_rf_wdata = wb.rf_wdata;
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard-driven checks of writeback select, HI/LO and trace
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    typedef struct packed {
        logic        rf_wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  dbg_wen;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;
    exp_t sb[$];

    wb_stage_if bus();

    wb_stage #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input w_reg_t m);
        bus.m_valid      = m.valid;
        bus.m_regwrite   = m.regwrite;
        bus.m_memtoreg   = m.memtoreg;
        bus.m_mfc0       = m.mfc0;
        bus.m_link       = m.link;
        bus.m_hi_wen     = m.hi_wen;
        bus.m_lo_wen     = m.lo_wen;
        bus.m_load_type  = m.load_type;
        bus.m_reg_waddr  = m.reg_waddr;
        bus.m_ex_out     = m.ex_out;
        bus.m_data_rdata = m.data_rdata;
        bus.m_cp0_rdata  = m.cp0_rdata;
        bus.m_pc         = m.pc;
        bus.m_hi_wdata   = m.hi_wdata;
        bus.m_lo_wdata   = m.lo_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic w_reg_t nop();
        w_reg_t m;
        m = '0;
        return m;
    endfunction

    function automatic w_reg_t mk_load(input load_t lt, input logic [4:0] wa, input logic [31:0] ex,
                                       input logic [31:0] rd, input logic [31:0] pc);
        w_reg_t m;
        m = '0;
        m.valid      = 1'b1;
        m.regwrite   = 1'b1;
        m.memtoreg   = 1'b1;
        m.load_type  = lt;
        m.reg_waddr  = wa;
        m.ex_out     = ex;
        m.data_rdata = rd;
        m.pc         = pc;
        return m;
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] off, input load_t lt);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> {off, 3'b000};
        h = off[1] ? rd >> 16 : rd;
        case (lt)
            LD_B:    return {{24{b[7]}}, b[7:0]};
            LD_BU:   return {24'h0, b[7:0]};
            LD_H:    return {{16{h[15]}}, h[15:0]};
            LD_HU:   return {16'h0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic test_reset();
        w_reg_t m;
        m = mk_load(LD_W, 5'd3, 32'h5, 32'h1, 32'h100);
        m.hi_wen = 1'b1;
        m.hi_wdata = 32'h1;
        rst = 1'b0;
        drive(m);
        tick();
        total++; if (bus.w_valid !== 1'b0) $display("FAIL reset_w_valid: got %b want 0", bus.w_valid); else passed++;
        total++; if (bus.rf_wen !== 1'b0) $display("FAIL reset_rf_wen: got %b want 0", bus.rf_wen); else passed++;
        total++; if (bus.rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr: got %0d want 0", bus.rf_waddr); else passed++;
        total++; if (bus.rf_wdata !== 32'h0) $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); else passed++;
        total++; if (bus.hi_rdata !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi_rdata); else passed++;
        total++; if (bus.lo_rdata !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo_rdata); else passed++;
        total++; if (bus.debug_wb_pc !== RPC) $display("FAIL reset_dbg_pc: got %h want %h", bus.debug_wb_pc, RPC); else passed++;
        total++; if (bus.debug_wb_rf_wen !== 4'h0) $display("FAIL reset_dbg_wen: got %h want 0", bus.debug_wb_rf_wen); else passed++;
        rst = 1'b1;
        drive(nop());
    endtask

    task automatic test_loads();
        load_t       lts[8]  = '{LD_W, LD_B, LD_BU, LD_H, LD_HU, LD_B, LD_H, LD_HU};
        logic [31:0] exs[8]  = '{32'h1004, 32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1000, 32'h1000};
        logic [31:0] rds[8]  = '{32'h8899AABB, 32'h80112233, 32'h80112233, 32'h80112233,
                                 32'h80112233, 32'h80112233, 32'h0000F00D, 32'h0000F00D};
        logic [31:0] want[8] = '{32'h8899AABB, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8011,
                                 32'h00002233, 32'h00000022, 32'hFFFFF00D, 32'h0000F00D};
        w_reg_t m;
        exp_t   e;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{1'b1, 5'(i + 1), want[i], 4'hF, 32'h0040_0000 + 32'(4 * i)});
            drive(mk_load(lts[i], 5'(i + 1), exs[i], rds[i], 32'h0040_0000 + 32'(4 * i)));
            tick();
            e = sb.pop_front();
            total++; if (bus.rf_wdata !== e.wdata) $display("FAIL load%0d_wdata: got %h want %h", i, bus.rf_wdata, e.wdata); else passed++;
            total++; if (bus.rf_wen !== e.rf_wen || bus.rf_waddr !== e.waddr) $display("FAIL load%0d_wen_waddr: got %b/%0d want %b/%0d", i, bus.rf_wen, bus.rf_waddr, e.rf_wen, e.waddr); else passed++;
            total++; if (bus.debug_wb_rf_wen !== e.dbg_wen || bus.debug_wb_pc !== e.pc) $display("FAIL load%0d_debug: got %h/%h want %h/%h", i, bus.debug_wb_rf_wen, bus.debug_wb_pc, e.dbg_wen, e.pc); else passed++;
        end
        m = nop();
        m.valid = 1'b1;
        m.regwrite = 1'b1;
        m.mfc0 = 1'b1;
        m.link = 1'b1;
        m.reg_waddr = 5'd8;
        m.cp0_rdata = 32'hCAFE0001;
        m.ex_out = 32'h33;
        m.pc = 32'h0040_0100;
        sb.push_back('{1'b1, 5'd8, 32'hCAFE0001, 4'hF, 32'h0040_0100});
        drive(m);
        tick();
        e = sb.pop_front();
        total++; if (bus.rf_wdata !== e.wdata) $display("FAIL mfc0_wdata: got %h want %h", bus.rf_wdata, e.wdata); else passed++;
        total++; if (bus.debug_wb_rf_wdata !== e.wdata || bus.debug_wb_rf_wnum !== e.waddr) $display("FAIL mfc0_debug: got %h/%0d want %h/%0d", bus.debug_wb_rf_wdata, bus.debug_wb_rf_wnum, e.wdata, e.waddr); else passed++;
    endtask

    task automatic test_link();
        logic [31:0] pcs[3]  = '{32'h0040_0010, 32'hFFFF_FFFC, 32'h0040_0020};
        logic [4:0]  was[3]  = '{5'd31, 5'd31, 5'd0};
        logic        lks[3]  = '{1'b1, 1'b1, 1'b0};
        exp_t        exps[3] = '{'{1'b1, 5'd31, 32'h0040_0018, 4'hF, 32'h0040_0010},
                                 '{1'b1, 5'd31, 32'h0000_0004, 4'hF, 32'hFFFF_FFFC},
                                 '{1'b0, 5'd0,  32'h0000_1234, 4'h0, 32'h0040_0020}};
        w_reg_t m;
        exp_t   e;
        for (int i = 0; i < 3; i++) begin
            m = nop();
            m.valid = 1'b1;
            m.regwrite = 1'b1;
            m.link = lks[i];
            m.reg_waddr = was[i];
            m.ex_out = 32'h1234;
            m.pc = pcs[i];
            sb.push_back(exps[i]);
            drive(m);
            tick();
            e = sb.pop_front();
            total++; if (bus.rf_wen !== e.rf_wen) $display("FAIL link%0d_wen: got %b want %b", i, bus.rf_wen, e.rf_wen); else passed++;
            total++; if (bus.rf_wdata !== e.wdata) $display("FAIL link%0d_wdata: got %h want %h", i, bus.rf_wdata, e.wdata); else passed++;
            total++; if (bus.debug_wb_rf_wen !== e.dbg_wen) $display("FAIL link%0d_dbg_wen: got %h want %h", i, bus.debug_wb_rf_wen, e.dbg_wen); else passed++;
        end
    endtask

    task automatic test_hilo_stall();
        w_reg_t m;
        exp_t   e;
        m = nop();
        m.valid = 1'b1;
        m.hi_wen = 1'b1;
        m.hi_wdata = 32'h12345678;
        m.pc = 32'h0040_0200;
        sb.push_back('{1'b0, 5'd0, 32'h0, 4'h0, 32'h0040_0200});
        drive(m);
        tick();
        total++; if (bus.hi_rdata !== 32'h12345678) $display("FAIL mthi_bypass: got %h want 12345678", bus.hi_rdata); else passed++;
        bus.w_stall = 1'b1;
        m = nop();
        m.valid = 1'b1;
        m.regwrite = 1'b1;
        m.reg_waddr = 5'd4;
        m.ex_out = 32'h77;
        m.hi_wdata = 32'hFFFFFFFF;
        m.pc = 32'h0040_0204;
        drive(m);
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (bus.hi_rdata !== 32'h12345678) $display("FAIL stall%0d_hi: got %h want 12345678", c, bus.hi_rdata); else passed++;
            total++; if (bus.debug_wb_rf_wen !== e.dbg_wen) $display("FAIL stall%0d_dbg_wen: got %h want %h", c, bus.debug_wb_rf_wen, e.dbg_wen); else passed++;
            total++; if (bus.debug_wb_pc !== e.pc || bus.w_valid !== 1'b1) $display("FAIL stall%0d_hold: got %h/%b want %h/1", c, bus.debug_wb_pc, bus.w_valid, e.pc); else passed++;
        end
        bus.w_stall = 1'b0;
        sb.push_back('{1'b1, 5'd4, 32'h77, 4'hF, 32'h0040_0204});
        tick();
        e = sb.pop_front();
        total++; if (bus.hi_rdata !== 32'h12345678) $display("FAIL mthi_commit: got %h want 12345678", bus.hi_rdata); else passed++;
        total++; if (bus.lo_rdata !== 32'h0) $display("FAIL mthi_lo_untouched: got %h want 0", bus.lo_rdata); else passed++;
        total++; if (bus.rf_wdata !== e.wdata || bus.debug_wb_rf_wen !== e.dbg_wen) $display("FAIL after_stall: got %h/%h want %h/%h", bus.rf_wdata, bus.debug_wb_rf_wen, e.wdata, e.dbg_wen); else passed++;
        bus.w_stall = 1'b1;
        tick();
        total++; if (bus.rf_wen !== 1'b1 || bus.debug_wb_rf_wen !== 4'h0) $display("FAIL stalled_gpr: got %b/%h want 1/0", bus.rf_wen, bus.debug_wb_rf_wen); else passed++;
        bus.w_stall = 1'b0;
        drive(nop());
        tick();
    endtask

    task automatic test_flush();
        w_reg_t m;
        m = nop();
        m.valid = 1'b1;
        m.regwrite = 1'b1;
        m.reg_waddr = 5'd9;
        m.hi_wen = 1'b1;
        m.lo_wen = 1'b1;
        m.hi_wdata = 32'hDEAD0000;
        m.lo_wdata = 32'hBEEF0000;
        bus.w_flush = 1'b1;
        drive(m);
        tick();
        total++; if (bus.w_valid !== 1'b0 || bus.rf_wen !== 1'b0) $display("FAIL flush_kill: got %b/%b want 0/0", bus.w_valid, bus.rf_wen); else passed++;
        total++; if (bus.hi_rdata !== 32'h12345678 || bus.lo_rdata !== 32'h0) $display("FAIL flush_hilo: got %h/%h want 12345678/0", bus.hi_rdata, bus.lo_rdata); else passed++;
        bus.w_flush = 1'b0;
        drive(nop());
        tick();
        total++; if (bus.hi_rdata !== 32'h12345678 || bus.lo_rdata !== 32'h0) $display("FAIL flush_no_commit: got %h/%h want 12345678/0", bus.hi_rdata, bus.lo_rdata); else passed++;
        m = nop();
        m.valid = 1'b1;
        m.regwrite = 1'b1;
        m.reg_waddr = 5'd10;
        m.ex_out = 32'hABC;
        drive(m);
        tick();
        bus.w_stall = 1'b1;
        bus.w_flush = 1'b1;
        m.reg_waddr = 5'd11;
        drive(m);
        tick();
        total++; if (bus.w_valid !== 1'b1 || bus.rf_waddr !== 5'd10) $display("FAIL stall_beats_flush: got %b/%0d want 1/10", bus.w_valid, bus.rf_waddr); else passed++;
        bus.w_stall = 1'b0;
        bus.w_flush = 1'b0;
        drive(nop());
        tick();
    endtask

    task automatic test_reset_commit();
        w_reg_t m;
        m = nop();
        m.valid = 1'b1;
        m.hi_wen = 1'b1;
        m.lo_wen = 1'b1;
        m.hi_wdata = 32'hAAAA0001;
        m.lo_wdata = 32'h55550002;
        m.pc = 32'h0040_0300;
        drive(m);
        tick();
        total++; if (bus.hi_rdata !== 32'hAAAA0001 || bus.lo_rdata !== 32'h55550002) $display("FAIL mult_bypass: got %h/%h want aaaa0001/55550002", bus.hi_rdata, bus.lo_rdata); else passed++;
        rst = 1'b0;
        drive(nop());
        tick();
        total++; if (bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'h0) $display("FAIL rst_commit_hilo: got %h/%h want 0/0", bus.hi_rdata, bus.lo_rdata); else passed++;
        total++; if (bus.w_valid !== 1'b0 || bus.debug_wb_pc !== RPC) $display("FAIL rst_commit_w: got %b/%h want 0/%h", bus.w_valid, bus.debug_wb_pc, RPC); else passed++;
        rst = 1'b1;
        tick();
        total++; if (bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'h0) $display("FAIL rst_commit_after: got %h/%h want 0/0", bus.hi_rdata, bus.lo_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        load_t       lt;
        logic [2:0]  k;
        logic [1:0]  off;
        logic [31:0] rd;
        logic [4:0]  wa;
        logic [31:0] pc;
        exp_t        e;
        for (int i = 0; i < 24; i++) begin
            k   = 3'($urandom_range(0, 4));
            lt  = load_t'(k);
            off = 2'($urandom_range(0, 3));
            off = (lt == LD_W) ? 2'b00 : (lt == LD_H || lt == LD_HU) ? {off[1], 1'b0} : off;
            rd  = $urandom;
            wa  = 5'($urandom_range(1, 31));
            pc  = 32'h0040_1000 + 32'(4 * i);
            sb.push_back('{1'b1, wa, ld_model(rd, off, lt), 4'hF, pc});
            drive(mk_load(lt, wa, {28'h0002000, 2'b00, off}, rd, pc));
            tick();
            e = sb.pop_front();
            total++; if (bus.rf_wdata !== e.wdata || bus.rf_waddr !== e.waddr) $display("FAIL b2b%0d: got %h/%0d want %h/%0d", i, bus.rf_wdata, bus.rf_waddr, e.wdata, e.waddr); else passed++;
        end
    endtask

    initial begin
        bus.w_stall = 1'b0;
        bus.w_flush = 1'b0;
        drive(nop());
        test_reset();
        test_loads();
        test_link();
        test_hilo_stall();
        test_flush();
        test_reset_commit();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
